// File: rtl/ping_pong_scheduler.sv
// Round-robin shared up/down ping-pong counter: two requesters each ask for a
// bounded sweep with a given number of direction reversals.
module ping_pong_scheduler #(
    parameter int WIDTH = 4,
    parameter int BW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] lo0,
    input  logic [WIDTH-1:0] hi0,
    input  logic [WIDTH-1:0] lo1,
    input  logic [WIDTH-1:0] hi1,
    input  logic [BW-1:0]    bnc0,
    input  logic [BW-1:0]    bnc1,
    input  logic             hold,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH-1:0] out,
    output logic             direction,
    output logic [1:0]       done,
    output logic [1:0]       err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic             dir_reg, dir_next;
    logic [BW-1:0]    rc_reg, rc_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [BW-1:0]    bnc_reg, bnc_next;
    logic [1:0]       gnt_reg, gnt_next;
    logic             last_reg, last_next;
    logic [1:0]       done_reg, done_next;
    logic [1:0]       err_reg, err_next;
    logic             busy_reg, busy_next;

    logic             win;
    logic [1:0]       win_onehot;
    logic [WIDTH-1:0] win_lo, win_hi;
    logic [BW-1:0]    win_bnc;
    logic             at_bound;

    // When both request, the one not granted last time wins.
    assign win     = (req[0] && req[1]) ? ~last_reg : req[1];
    assign win_lo  = win ? lo1 : lo0;
    assign win_hi  = win ? hi1 : hi0;
    assign win_bnc = win ? bnc1 : bnc0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_onehot
            assign win_onehot[gi] = (win == 1'(gi));
        end
    endgenerate

    assign at_bound = dir_reg ? (out_reg == hi_reg) : (out_reg == lo_reg);

    always_comb begin
        state_next = state_reg;
        out_next   = out_reg;
        dir_next   = dir_reg;
        rc_next    = rc_reg;
        lo_next    = lo_reg;
        hi_next    = hi_reg;
        bnc_next   = bnc_reg;
        gnt_next   = gnt_reg;
        last_next  = last_reg;
        done_next  = 2'b00;
        err_next   = 2'b00;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    last_next = win;
                    if (win_lo < win_hi) begin
                        lo_next    = win_lo;
                        hi_next    = win_hi;
                        bnc_next   = win_bnc;
                        out_next   = win_lo;
                        dir_next   = 1'b1;
                        rc_next    = '0;
                        gnt_next   = win_onehot;
                        state_next = RUN;
                    end else begin
                        err_next = win_onehot;
                    end
                end
            end
            RUN: begin
                if (!hold) begin
                    if (at_bound) begin
                        if (rc_reg == bnc_reg) begin
                            state_next = DONE;
                            done_next  = gnt_reg;
                        end else begin
                            // Reverse and step away from the bound in the same cycle.
                            dir_next = ~dir_reg;
                            out_next = dir_reg ? out_reg - 1'b1 : out_reg + 1'b1;
                            rc_next  = rc_reg + 1'b1;
                        end
                    end else begin
                        out_next = dir_reg ? out_reg + 1'b1 : out_reg - 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                gnt_next   = 2'b00;
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            out_reg   <= '0;
            dir_reg   <= 1'b1;
            rc_reg    <= '0;
            lo_reg    <= '0;
            hi_reg    <= '0;
            bnc_reg   <= '0;
            gnt_reg   <= 2'b00;
            last_reg  <= 1'b1;
            done_reg  <= 2'b00;
            err_reg   <= 2'b00;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            out_reg   <= out_next;
            dir_reg   <= dir_next;
            rc_reg    <= rc_next;
            lo_reg    <= lo_next;
            hi_reg    <= hi_next;
            bnc_reg   <= bnc_next;
            gnt_reg   <= gnt_next;
            last_reg  <= last_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            busy_reg  <= busy_next;
        end
    end

    assign gnt       = gnt_reg;
    assign busy      = busy_reg;
    assign out       = out_reg;
    assign direction = dir_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule
